// File: rtl/icache_fetch_port_pkg.sv
// ============================================================================
// Module      : icache_fetch_port_pkg
// Description : Shared definitions for the instruction-fetch port: FSM state
//               encoding, line geometry and refill beat counter width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_fetch_port_pkg;

  // Instruction words per cache line.
  localparam int LINE_WORDS = 4;

  // Refill beat counter width; counts exactly LINE_WORDS beats.
  localparam int BEAT_W = 2;

  // Index of the final refill beat.
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/icache_linebuf.sv
// ============================================================================
// Module      : icache_linebuf
// Description : Single-line instruction buffer. Holds one valid/tag/data
//               entry, loaded on every completed refill and compared against
//               the tag of the incoming fetch request.
// Ports       : clk_i, rst_ni     - clock, asynchronous active-low reset
//               load_i            - write the entry (completed refill)
//               load_tag_i/data_i - tag and line to store
//               lookup_tag_i      - tag of the current request
//               hit_o             - entry valid and tag match
//               data_o            - stored line
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_linebuf
  import icache_fetch_port_pkg::*;
#(
  parameter int TAG_W  = 28,
  parameter int LINE_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [TAG_W-1:0]  load_tag_i,
  input  logic [LINE_W-1:0] load_data_i,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  output logic              hit_o,
  output logic [LINE_W-1:0] data_o
);

  logic              valid_q;
  logic [TAG_W-1:0]  tag_q;
  logic [LINE_W-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      tag_q   <= load_tag_i;
      data_q  <= load_data_i;
    end
  end

  assign hit_o  = valid_q && (tag_q == lookup_tag_i);
  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/icache_fetch_port.sv
// ============================================================================
// Module      : icache_fetch_port
// Description : Instruction-fetch port. Accepts line fetch requests from the
//               IFU, refills the line from memory one word per beat (single
//               outstanding read), and returns the whole line with a one-cycle
//               response pulse. Flushes abort an in-flight refill; a read
//               already issued is drained before returning to idle.
// Config      : ICACHE_LINEBUF_EN - when defined, a one-line buffer turns
//               repeat fetches of the last refilled line into one-cycle hits.
// Ports       : iClk, iResetn                - clock, async active-low reset
//               fromIfu_req/pc, iFlush       - fetch request, address, abort
//               toIfu_resp, toIfu_instr      - response pulse and line
//               toMem_req/addr               - word read request
//               fromMem_vld/data             - read completion and data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_fetch_port
  import icache_fetch_port_pkg::*;
#(
  parameter int PCW = 32,
  parameter int IW  = 32
) (
  input  logic                     iClk,
  input  logic                     iResetn,
  input  logic                     fromIfu_req,
  input  logic [PCW-1:0]           fromIfu_pc,
  input  logic                     iFlush,
  output logic                     toIfu_resp,
  output logic [IW*LINE_WORDS-1:0] toIfu_instr,
  output logic                     toMem_req,
  output logic [PCW-1:0]           toMem_addr,
  input  logic                     fromMem_vld,
  input  logic [IW-1:0]            fromMem_data
);

  localparam int TAG_W  = PCW - 4;
  localparam int LINE_W = IW * LINE_WORDS;

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              resp_q, resp_d;
  logic [LINE_W-1:0] instr_q, instr_d;
  logic [LINE_W-1:0] stage_q, stage_d;
  logic              mem_req_q, mem_req_d;
  logic [PCW-1:0]    addr_q, addr_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  logic [TAG_W-1:0]  w_pc_tag;
  logic [LINE_W-1:0] w_fill;
  logic              w_lb_load;
  logic              w_lb_hit;
  logic [LINE_W-1:0] w_lb_data;
  logic              w_unused_pc;

  assign w_pc_tag    = fromIfu_pc[PCW-1:4];
  // Byte offset within the line does not select anything.
  assign w_unused_pc = ^fromIfu_pc[3:0];

`ifdef ICACHE_LINEBUF_EN
  icache_linebuf #(
    .TAG_W  (TAG_W),
    .LINE_W (LINE_W)
  ) u_linebuf (
    .clk_i        (iClk),
    .rst_ni       (iResetn),
    .load_i       (w_lb_load),
    .load_tag_i   (tag_q),
    .load_data_i  (w_fill),
    .lookup_tag_i (w_pc_tag),
    .hit_o        (w_lb_hit),
    .data_o       (w_lb_data)
  );
`else
  logic w_unused_lb;
  assign w_lb_hit    = 1'b0;
  assign w_lb_data   = '0;
  assign w_unused_lb = w_lb_load;
`endif

  always_ff @(posedge iClk or negedge iResetn) begin
    if (!iResetn) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      resp_q    <= 1'b0;
      instr_q   <= '0;
      stage_q   <= '0;
      mem_req_q <= 1'b0;
      addr_q    <= '0;
      tag_q     <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      resp_q    <= resp_d;
      instr_q   <= instr_d;
      stage_q   <= stage_d;
      mem_req_q <= mem_req_d;
      addr_q    <= addr_d;
      tag_q     <= tag_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    resp_d    = 1'b0;
    instr_d   = instr_q;
    stage_d   = stage_q;
    mem_req_d = mem_req_q;
    addr_d    = addr_q;
    tag_d     = tag_q;
    w_lb_load = 1'b0;

    // Staging line with the current beat's read data merged in.
    w_fill = stage_q;
    w_fill[int'(beat_q)*IW +: IW] = fromMem_data;

    unique case (state_q)
      ST_IDLE: begin
        if (fromIfu_req && !iFlush) begin
          tag_d = w_pc_tag;
          if (w_lb_hit) begin
            state_d = ST_RESP;
            resp_d  = 1'b1;
            instr_d = w_lb_data;
          end else begin
            state_d   = ST_REFILL;
            beat_d    = '0;
            mem_req_d = 1'b1;
            addr_d    = {w_pc_tag, {BEAT_W{1'b0}}, 2'b00};
          end
        end
      end

      ST_REFILL: begin
        if (fromMem_vld) begin
          if (iFlush) begin
            // Read is complete, nothing left to drain: drop it and go idle.
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
          end else if (beat_q == LAST_BEAT) begin
            state_d   = ST_RESP;
            resp_d    = 1'b1;
            instr_d   = w_fill;
            stage_d   = w_fill;
            mem_req_d = 1'b0;
            w_lb_load = 1'b1;
          end else begin
            stage_d = w_fill;
            beat_d  = beat_q + 1'b1;
            addr_d  = {tag_q, beat_q + 1'b1, 2'b00};
          end
        end else if (iFlush) begin
          // Outstanding read must still complete; keep request/address.
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (fromMem_vld) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      end

      ST_RESP: begin
        // Response pulse is already on the output; request ignored here.
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign toIfu_resp  = resp_q;
  assign toIfu_instr = instr_q;
  assign toMem_req   = mem_req_q;
  assign toMem_addr  = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_icache_fetch_port.sv
// ============================================================================
// Module      : tb_icache_fetch_port
// Description : Self-checking bench for icache_fetch_port. A memory responder
//               answers reads (optionally stalling one beat); expected lines
//               are queued when a fetch is issued and compared when the
//               response pulse appears. Honours ICACHE_LINEBUF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_fetch_port;

`ifdef ICACHE_LINEBUF_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic         iClk;
  logic         iResetn;
  logic         fromIfu_req;
  logic [31:0]  fromIfu_pc;
  logic         iFlush;
  logic         toIfu_resp;
  logic [127:0] toIfu_instr;
  logic         toMem_req;
  logic [31:0]  toMem_addr;
  logic         fromMem_vld;
  logic [31:0]  fromMem_data;

  icache_fetch_port #(.PCW(32), .IW(32)) dut (
    .iClk         (iClk),
    .iResetn      (iResetn),
    .fromIfu_req  (fromIfu_req),
    .fromIfu_pc   (fromIfu_pc),
    .iFlush       (iFlush),
    .toIfu_resp   (toIfu_resp),
    .toIfu_instr  (toIfu_instr),
    .toMem_req    (toMem_req),
    .toMem_addr   (toMem_addr),
    .fromMem_vld  (fromMem_vld),
    .fromMem_data (fromMem_data)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_resp = 0;

  logic [127:0] sb[$];      // expected lines, pushed at request
  logic [127:0] obs_q[$];   // observed lines, pushed by monitor
  logic [31:0]  addr_log[$];
  int           rd_cnt = 0;
  int           resp_cnt = 0;
  int           stall_cnt = 0;

  bit           lb_v = 1'b0;
  logic [27:0]  lb_tag = '0;

  bit           stall_en = 1'b0;
  logic [1:0]   stall_beat = 2'd1;
  int           stall_len = 20;
  int           mcnt = 0;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return 32'hA0 + ((a - 32'h100) >> 2);
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] pc);
    logic [31:0] b;
    b = {pc[31:4], 4'h0};
    return {mw(b + 32'd12), mw(b + 32'd8), mw(b + 32'd4), mw(b)};
  endfunction

  // Memory responder: answers each address after a delay (1 cycle default).
  always @(posedge iClk) begin
    #1;
    if (!iResetn || !toMem_req) begin
      fromMem_vld = 1'b0;
      mcnt = 0;
    end else if (fromMem_vld) begin
      fromMem_vld = 1'b0;
      mcnt = 1;
    end else if (mcnt >= ((stall_en && toMem_addr[3:2] == stall_beat) ? stall_len : 1)) begin
      fromMem_vld  = 1'b1;
      fromMem_data = mw(toMem_addr);
    end else begin
      mcnt++;
    end
  end

  // Monitor: records reads, stall cycles and responses.
  always @(negedge iClk) begin
    if (iResetn) begin
      if (fromMem_vld && toMem_req) begin
        rd_cnt++;
        addr_log.push_back(toMem_addr);
      end
      if (toMem_req && !fromMem_vld && toMem_addr == 32'h104) stall_cnt++;
      if (toIfu_resp) begin
        resp_cnt++;
        obs_q.push_back(toIfu_instr);
      end
    end
  end

  // Issue a fetch and check the response. Called and returns at posedge+1.
  task automatic fetch(input logic [31:0] pc, input int miss_lat, input bit keep);
    bit           hit;
    bit           got;
    int           n, lat, rd0, exp_lat;
    logic [127:0] e, o;
    hit     = LB && lb_v && (lb_tag == pc[31:4]);
    exp_lat = hit ? 1 : miss_lat;
    sb.push_back(line_of(pc));
    exp_resp++;
    rd0 = rd_cnt;
    fromIfu_pc  = pc;
    fromIfu_req = 1'b1;
    n   = cyc;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge iClk);
      if (toIfu_resp) begin
        got = 1'b1;
        break;
      end
    end
    lat = cyc - n;
    @(posedge iClk); #1;
    if (!keep) fromIfu_req = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL fetch_timeout pc=%h: no resp within 200 cycles, required a resp", pc);
      void'(sb.pop_front());
    end else begin
      if (lat != exp_lat) begin
        n_bad++;
        $display("FAIL latency pc=%h: got %0d, required %0d", pc, lat, exp_lat);
      end
      n_cmp++;
      e = sb.pop_front();
      if (obs_q.size() == 0) begin
        n_bad++;
        $display("FAIL resp_line pc=%h: no line observed, required %h", pc, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL resp_line pc=%h: got %h, required %h", pc, o, e);
        end
      end
      n_cmp++;
      if (rd_cnt - rd0 != (hit ? 0 : 4)) begin
        n_bad++;
        $display("FAIL mem_reads pc=%h: got %0d, required %0d", pc, rd_cnt - rd0, hit ? 0 : 4);
      end
    end
    if (!hit) begin
      lb_v   = 1'b1;
      lb_tag = pc[31:4];
    end
  endtask

  task automatic test_reset();
    iResetn     = 1'b0;
    fromIfu_req = 1'b0;
    fromIfu_pc  = '0;
    iFlush      = 1'b0;
    fromMem_vld = 1'b0;
    fromMem_data = '0;
    repeat (3) @(posedge iClk);
    #1;
    n_cmp += 4;
    if (toIfu_resp !== 1'b0) begin n_bad++; $display("FAIL reset_resp: got %b, required 0", toIfu_resp); end
    if (toIfu_instr !== 128'h0) begin n_bad++; $display("FAIL reset_instr: got %h, required 0", toIfu_instr); end
    if (toMem_req !== 1'b0) begin n_bad++; $display("FAIL reset_memreq: got %b, required 0", toMem_req); end
    if (toMem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h, required 0", toMem_addr); end
    @(negedge iClk);
    iResetn = 1'b1;
    @(posedge iClk); #1;
  endtask

  task automatic test_basic_miss();
    int a0;
    a0 = addr_log.size();
    fetch(32'h100, 9, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (addr_log.size() < a0 + 4) begin
        n_bad++;
        $display("FAIL miss_addr%0d: only %0d reads logged, required 4", k, addr_log.size() - a0);
      end else if (addr_log[a0 + k] !== 32'h100 + 32'(4 * k)) begin
        n_bad++;
        $display("FAIL miss_addr%0d: got %h, required %h", k, addr_log[a0 + k], 32'h100 + 32'(4 * k));
      end
    end
    n_cmp++;
    if (toIfu_instr !== 128'h000000A3_000000A2_000000A1_000000A0) begin
      n_bad++;
      $display("FAIL miss_line_held: got %h, required 000000a3000000a2000000a1000000a0", toIfu_instr);
    end
  endtask

  task automatic test_linebuf_hit();
    fetch(32'h108, 9, 1'b0);
  endtask

  task automatic test_back_to_back();
    fetch(32'h100, 9, 1'b1);
    fetch(32'h200, 9, 1'b0);
    repeat (3) @(posedge iClk);
    #1;
    n_cmp++;
    if (resp_cnt != exp_resp) begin
      n_bad++;
      $display("FAIL b2b_resp_count: got %0d, required %0d", resp_cnt, exp_resp);
    end
  endtask

  task automatic test_flush_drain();
    logic [127:0] held;
    int           rd0;
    bit           found;
    held  = toIfu_instr;
    rd0   = rd_cnt;
    found = 1'b0;
    fromIfu_pc  = 32'h100;
    fromIfu_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge iClk); #1;
      if (toMem_req && toMem_addr == 32'h108) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL drain_reach_beat2: got no read of 108, required one");
    end
    iFlush      = 1'b1;
    fromIfu_req = 1'b0;
    @(posedge iClk); #1;
    iFlush = 1'b0;
    n_cmp++;
    if (toMem_req !== 1'b1 || toMem_addr !== 32'h108) begin
      n_bad++;
      $display("FAIL drain_hold: got req=%b addr=%h, required req=1 addr=108", toMem_req, toMem_addr);
    end
    @(posedge iClk); #1;
    n_cmp++;
    if (toMem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_release: got req=%b, required 0", toMem_req);
    end
    repeat (4) @(posedge iClk);
    #1;
    n_cmp += 3;
    if (rd_cnt - rd0 != 3) begin n_bad++; $display("FAIL drain_reads: got %0d, required 3", rd_cnt - rd0); end
    if (resp_cnt != exp_resp) begin n_bad++; $display("FAIL drain_no_resp: got %0d resps, required %0d", resp_cnt, exp_resp); end
    if (toIfu_instr !== held) begin n_bad++; $display("FAIL drain_instr_kept: got %h, required %h", toIfu_instr, held); end
    fetch(32'h100, 9, 1'b0);
  endtask

  task automatic test_flush_same_cycle();
    int  rd0;
    bit  found;
    rd0   = rd_cnt;
    found = 1'b0;
    fromIfu_pc  = 32'h300;
    fromIfu_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge iClk); #1;
      if (toMem_req && toMem_addr == 32'h304) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL samecyc_reach_beat1: got no read of 304, required one");
    end
    @(posedge iClk); #1;
    iFlush      = 1'b1;
    fromIfu_req = 1'b0;
    @(posedge iClk); #1;
    iFlush = 1'b0;
    n_cmp += 2;
    if (toMem_req !== 1'b0) begin n_bad++; $display("FAIL samecyc_req_low: got %b, required 0", toMem_req); end
    if (rd_cnt - rd0 != 2) begin n_bad++; $display("FAIL samecyc_reads: got %0d, required 2", rd_cnt - rd0); end
    repeat (4) @(posedge iClk);
    #1;
    n_cmp++;
    if (resp_cnt != exp_resp) begin n_bad++; $display("FAIL samecyc_no_resp: got %0d resps, required %0d", resp_cnt, exp_resp); end
  endtask

  task automatic test_flush_idle();
    fromIfu_pc  = 32'h400;
    fromIfu_req = 1'b1;
    iFlush      = 1'b1;
    @(posedge iClk); #1;
    fromIfu_req = 1'b0;
    iFlush      = 1'b0;
    n_cmp += 2;
    if (toMem_req !== 1'b0) begin n_bad++; $display("FAIL idleflush_req: got %b, required 0", toMem_req); end
    if (toIfu_resp !== 1'b0) begin n_bad++; $display("FAIL idleflush_resp: got %b, required 0", toIfu_resp); end
    repeat (3) @(posedge iClk);
    #1;
  endtask

  task automatic test_async_reset();
    bit found;
    found = 1'b0;
    fromIfu_pc  = 32'h300;
    fromIfu_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge iClk); #1;
      if (toMem_req && toMem_addr == 32'h304) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL arst_reach_beat1: got no read of 304, required one");
    end
    #1;
    iResetn     = 1'b0;
    fromIfu_req = 1'b0;
    #1;
    n_cmp += 4;
    if (toIfu_resp !== 1'b0) begin n_bad++; $display("FAIL arst_resp: got %b, required 0", toIfu_resp); end
    if (toIfu_instr !== 128'h0) begin n_bad++; $display("FAIL arst_instr: got %h, required 0", toIfu_instr); end
    if (toMem_req !== 1'b0) begin n_bad++; $display("FAIL arst_memreq: got %b, required 0", toMem_req); end
    if (toMem_addr !== 32'h0) begin n_bad++; $display("FAIL arst_addr: got %h, required 0", toMem_addr); end
    lb_v = 1'b0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iResetn = 1'b1;
    repeat (4) @(posedge iClk);
    #1;
    n_cmp += 2;
    if (toMem_req !== 1'b0) begin n_bad++; $display("FAIL arst_no_resume: got req=%b, required 0", toMem_req); end
    if (resp_cnt != exp_resp) begin n_bad++; $display("FAIL arst_no_resp: got %0d resps, required %0d", resp_cnt, exp_resp); end
  endtask

  task automatic test_mem_stall();
    int s0;
    s0         = stall_cnt;
    stall_beat = 2'd1;
    stall_len  = 20;
    stall_en   = 1'b1;
    fetch(32'h100, 28, 1'b0);
    stall_en = 1'b0;
    n_cmp++;
    if (stall_cnt - s0 != 20) begin
      n_bad++;
      $display("FAIL stall_hold_104: got %0d cycles, required 20", stall_cnt - s0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_miss();
    test_linebuf_hit();
    test_back_to_back();
    test_flush_drain();
    test_flush_same_cycle();
    test_flush_idle();
    test_async_reset();
    test_mem_stall();
    repeat (5) @(posedge iClk);
    #1;
    n_cmp += 2;
    if (resp_cnt != exp_resp) begin n_bad++; $display("FAIL final_resp_count: got %0d, required %0d", resp_cnt, exp_resp); end
    if (sb.size() != 0 || obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL final_queues: got sb=%0d obs=%0d, required 0/0", sb.size(), obs_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/icache_fetch_port.md
ICACHE_FETCH_PORT -- requirements
Module: icache_fetch_port

Interface
REQ-001 Parameter PCW, default 32, PC/address width.
REQ-002 Parameter IW, default 32, instruction width; line = 4 instructions (IW*4 bits).
REQ-003 iClk  in  1  sole clock, all state on rising edge.
REQ-004 iResetn  in  1  reset, asynchronous, active-low.
REQ-005 fromIfu_req  in  1  fetch request, level, held with stable pc until toIfu_resp.
REQ-006 fromIfu_pc  in  PCW  fetch address; line = pc[PCW-1:4], pc[3:0] ignored.
REQ-007 iFlush  in  1  jump/abort; discards in-flight fetch.
REQ-008 toIfu_resp  out  1  one-cycle pulse: line delivered.
REQ-009 toIfu_instr  out  IW*4  line; word k (address line+4k) at bits [IW*(k+1)-1:IW*k]; registered, held until next resp.
REQ-010 toMem_req  out  1  memory word read request, level, held until fromMem_vld.
REQ-011 toMem_addr  out  PCW  word address {line,beat[1:0],2'b00}, stable while toMem_req high.
REQ-012 fromMem_vld  in  1  read completion for current toMem_addr; one outstanding read max.
REQ-013 fromMem_data  in  IW  read data, valid with fromMem_vld.

Function
REQ-014 FSM states IDLE, REFILL, DRAIN, RESP; all outputs registered.
REQ-015 IDLE: fromIfu_req=1 & iFlush=0 -> line-buffer hit ? RESP : REFILL with beat=0, toMem_req=1 next cycle; otherwise stay.
REQ-016 REFILL: on fromMem_vld capture fromMem_data into word[beat] of staging line; beat<3 -> beat+1, toMem_req stays high, addr advances next cycle; beat==3 -> RESP.
REQ-017 RESP: toIfu_resp=1 for exactly one cycle, toIfu_instr = completed line; fromIfu_req ignored this cycle; next state IDLE.
REQ-018 Latency: hit req first seen cycle N -> resp N+1; miss with memory answering 1 cycle after each req -> resp at N+9.
REQ-019 iFlush in IDLE or RESP: RESP pulse already scheduled still issues; no new request sampled that cycle.
REQ-020 iFlush in REFILL without same-cycle fromMem_vld -> DRAIN, toMem_req/addr held; fromMem_vld in DRAIN -> IDLE, data discarded.
REQ-021 iFlush in REFILL with same-cycle fromMem_vld -> IDLE directly, data discarded, toMem_req low next cycle.
REQ-022 Aborted refill never updates line buffer or toIfu_instr; no toIfu_resp.
REQ-023 fromMem_vld outside REFILL/DRAIN ignored.
REQ-024 beat counter 2 bits; completes at exactly 4 beats, no wrap beyond.

Reset
REQ-025 Reset: state IDLE, beat 0, toIfu_resp 0, toIfu_instr 0, toMem_req 0, toMem_addr 0, line buffer invalid.
REQ-026 Reset mid-refill abandons transaction; no completion expected after release.

Configuration
REQ-027 Macro ICACHE_LINEBUF_EN defined: one-line buffer (valid, tag=pc[PCW-1:4], data) loaded on each completed refill; IDLE request with valid & tag match is a hit.
REQ-028 Macro undefined: no line buffer, every request refills (REQ-015 hit term constant 0); ports unchanged.

Structure
REQ-029 Shared package holds FSM state encodings, LINE_WORDS=4, beat width 2.
REQ-030 One sub-module icache_linebuf (valid/tag/data, load, compare), instantiated only under ICACHE_LINEBUF_EN.

Verification
REQ-031 pc=0x100, mem returns 0xA0..0xA3 one cycle after each req -> addrs 0x100,0x104,0x108,0x10C; resp at N+9, instr=0x000000A3_000000A2_000000A1_000000A0.
REQ-032 ICACHE_LINEBUF_EN: repeat pc=0x108 after 0x100 fill -> resp at N+1, same line, toMem_req stays 0.
REQ-033 iFlush during beat 2 wait -> toMem_req held until vld, then IDLE; no resp; next pc=0x100 request refills (misses) with all 4 beats.
REQ-034 Memory stall 20 cycles on beat 1 -> toMem_req/addr 0x104 stable all 20 cycles; resp after beat 3.
REQ-035 fromIfu_req held high across resp cycle -> exactly one resp and one fetch per request; new pc=0x200 next cycle fetched.
REQ-036 iResetn low while in REFILL beat 1 -> all outputs 0 asynchronously; after release, pc=0x100 refetch completes normally.
